// File: rtl/range_counter_pkg.sv
// Shared types for the range counter: counting modes and direction encoding.
package range_counter_pkg;

    typedef enum logic [1:0] {
        WRAP     = 2'd0,
        SATURATE = 2'd1,
        BOUNCE   = 2'd2,
        ONESHOT  = 2'd3
    } mode_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/range_counter_next.sv
// Combinational next-count, wrap-pulse, done and direction computation.
module range_counter_next
    import range_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    input  mode_e             mode,
    input  logic              dir,
    output logic [WIDTH-1:0]  next_count,
    output logic              next_wrap,
    output logic              next_done,
    output logic              next_dir
);

    // One guard bit above the widest operand keeps count +/- step from aliasing.
    localparam int unsigned AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [AW-1:0] cnt_w, lo_w, hi_w, step_w, sum_w, dif_w, dn_lim_w;
    logic          out_of_range, over_up, reach_up, under_dn, reach_dn;

    assign cnt_w    = AW'(count);
    assign lo_w     = AW'(lo);
    assign hi_w     = AW'(hi);
    assign step_w   = (step == '0) ? AW'(1) : AW'(step);
    assign sum_w    = cnt_w + step_w;
    assign dif_w    = cnt_w - step_w;
    // count - step < lo is evaluated as count < lo + step to avoid underflow.
    assign dn_lim_w = lo_w + step_w;

    assign out_of_range = (count < lo) || (count > hi);
    assign over_up      = sum_w > hi_w;
    assign reach_up     = sum_w >= hi_w;
    assign under_dn     = cnt_w < dn_lim_w;
    assign reach_dn     = cnt_w <= dn_lim_w;

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_done  = 1'b0;
        next_dir   = dir;
        if (out_of_range) begin
            next_count = (dir == DIR_UP) ? lo : hi;
            next_wrap  = 1'b1;
        end else begin
            case (mode)
                WRAP: begin
                    if (dir == DIR_UP) begin
                        next_count = over_up ? lo : WIDTH'(sum_w);
                        next_wrap  = over_up;
                    end else begin
                        next_count = under_dn ? hi : WIDTH'(dif_w);
                        next_wrap  = under_dn;
                    end
                end
                SATURATE: begin
                    if (dir == DIR_UP) next_count = over_up ? hi : WIDTH'(sum_w);
                    else               next_count = under_dn ? lo : WIDTH'(dif_w);
                end
                BOUNCE: begin
                    if (dir == DIR_UP) begin
                        next_count = over_up ? hi : WIDTH'(sum_w);
                        next_wrap  = over_up;
                        next_dir   = over_up ? DIR_DN : DIR_UP;
                    end else begin
                        next_count = under_dn ? lo : WIDTH'(dif_w);
                        next_wrap  = under_dn;
                        next_dir   = under_dn ? DIR_UP : DIR_DN;
                    end
                end
                ONESHOT: begin
                    if (dir == DIR_UP) begin
                        next_count = reach_up ? hi : WIDTH'(sum_w);
                        next_done  = reach_up;
                    end else begin
                        next_count = reach_dn ? lo : WIDTH'(dif_w);
                        next_done  = reach_dn;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/range_counter.sv
// Bounded up/down counter with wrap, saturate, bounce and one-shot modes.
module range_counter
    import range_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrap,
    output logic              done,
    output logic              cfg_err
);

    mode_e            mode_m, mode_q;
    logic             dir_q, eff_dir, act_dir, bounce_entry, hold_done;
    logic [WIDTH-1:0] nxt_count;
    logic             nxt_wrap, nxt_done, nxt_dir;

    assign mode_m  = mode_e'(mode);
    assign cfg_err = lo > hi;

    // Entering BOUNCE re-seeds the bounce direction from up_dn.
    assign bounce_entry = (mode_m == BOUNCE) && (mode_q != BOUNCE);
    assign eff_dir      = bounce_entry ? up_dn : dir_q;
    assign act_dir      = (mode_m == BOUNCE) ? eff_dir : up_dn;
    assign hold_done    = done && (mode_m == ONESHOT);

    assign tc = ((count == hi) && (act_dir == DIR_UP)) ||
                ((count == lo) && (act_dir == DIR_DN));

    range_counter_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .count      (count),
        .lo         (lo),
        .hi         (hi),
        .step       (step),
        .mode       (mode_m),
        .dir        (act_dir),
        .next_count (nxt_count),
        .next_wrap  (nxt_wrap),
        .next_done  (nxt_done),
        .next_dir   (nxt_dir)
    );

    // Priority: reset > load > config error hold > enabled count > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wrap   <= 1'b0;
            done   <= 1'b0;
            dir_q  <= DIR_UP;
            mode_q <= WRAP;
        end else begin
            mode_q <= mode_m;
            if (load) begin
                count <= d_in;
                wrap  <= 1'b0;
                done  <= 1'b0;
                dir_q <= up_dn;
            end else if (!cfg_err && en && !hold_done) begin
                count <= nxt_count;
                wrap  <= nxt_wrap;
                done  <= done | nxt_done;
                dir_q <= nxt_dir;
            end else begin
                wrap  <= 1'b0;
                dir_q <= eff_dir;
            end
        end
    end

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter: directed vectors, queued expectations, decoupled monitor.
module tb_range_counter;

    logic       clk, rst, en, load, up_dn;
    logic [7:0] d_in, lo, hi, count;
    logic [3:0] step;
    logic [1:0] mode;
    logic       tc, wrap, done, cfg_err;

    typedef struct {
        int unsigned at;
        int          id;
        logic [7:0]  c;
        logic        w;
        logic        t;
        logic        d;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    range_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .d_in    (d_in),
        .up_dn   (up_dn),
        .step    (step),
        .lo      (lo),
        .hi      (hi),
        .mode    (mode),
        .count   (count),
        .tc      (tc),
        .wrap    (wrap),
        .done    (done),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL t%0d %s: got %0d expected %0d (cycle %0d)", id, nm, act, exp, cyc);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [7:0] l, input logic [7:0] h,
                       input logic [3:0] s, input logic ud);
        mode = m; lo = l; hi = h; step = s; up_dn = ud;
    endtask

    task automatic drive(input logic l, input logic e, input logic [7:0] d);
        load = l; en = e; d_in = d;
    endtask

    // Queue the expected state after the next rising edge, then move to the next falling edge.
    task automatic exp_edge(input int id, input logic [7:0] c, input logic w, input logic t, input logic d);
        exp_t e;
        e.at = cyc + 1; e.id = id; e.c = c; e.w = w; e.t = t; e.d = d;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each rising edge, pop and compare every expectation due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                chk(e.id, "count", 32'(count), 32'(e.c));
                chk(e.id, "wrap",  32'(wrap),  32'(e.w));
                chk(e.id, "tc",    32'(tc),    32'(e.t));
                chk(e.id, "done",  32'(done),  32'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        cfg(2'd0, 8'd0, 8'd0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk(0, "rst_count", 32'(count), 32'd0);
        chk(0, "rst_wrap",  32'(wrap),  32'd0);
        chk(0, "rst_done",  32'(done),  32'd0);
        rst = 1'b0;

        // WRAP up, step 1
        cfg(2'd0, 8'd3, 8'd12, 4'd1, 1'b0); drive(1'b1, 1'b0, 8'd11);
        exp_edge(1, 8'd11, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(1, 8'd12, 1'b0, 1'b1, 1'b0);
        exp_edge(1, 8'd3,  1'b1, 1'b0, 1'b0);
        exp_edge(1, 8'd4,  1'b0, 1'b0, 1'b0);

        // WRAP down, step 5
        cfg(2'd0, 8'd3, 8'd12, 4'd5, 1'b1); drive(1'b1, 1'b0, 8'd7);
        exp_edge(2, 8'd7,  1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(2, 8'd12, 1'b1, 1'b0, 1'b0);
        exp_edge(2, 8'd7,  1'b0, 1'b0, 1'b0);
        exp_edge(2, 8'd12, 1'b1, 1'b0, 1'b0);

        // step 0 behaves as step 1
        cfg(2'd0, 8'd3, 8'd12, 4'd0, 1'b0); drive(1'b1, 1'b0, 8'd4);
        exp_edge(3, 8'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(3, 8'd5, 1'b0, 1'b0, 1'b0);

        // SATURATE up at top of range, no alias to 9
        cfg(2'd1, 8'd0, 8'd255, 4'd15, 1'b0); drive(1'b1, 1'b0, 8'd250);
        exp_edge(4, 8'd250, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(4, 8'd255, 1'b0, 1'b1, 1'b0);
        exp_edge(4, 8'd255, 1'b0, 1'b1, 1'b0);

        // SATURATE down through zero clamps to lo
        cfg(2'd1, 8'd0, 8'd255, 4'd15, 1'b1); drive(1'b1, 1'b0, 8'd5);
        exp_edge(5, 8'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(5, 8'd0, 1'b0, 1'b1, 1'b0);

        // BOUNCE
        cfg(2'd2, 8'd2, 8'd5, 4'd2, 1'b0); drive(1'b1, 1'b0, 8'd2);
        exp_edge(6, 8'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(6, 8'd4, 1'b0, 1'b0, 1'b0);
        exp_edge(6, 8'd5, 1'b1, 1'b0, 1'b0);
        exp_edge(6, 8'd3, 1'b0, 1'b0, 1'b0);
        exp_edge(6, 8'd2, 1'b1, 1'b0, 1'b0);
        exp_edge(6, 8'd4, 1'b0, 1'b0, 1'b0);

        // ONESHOT: done sticks and count holds, load clears
        cfg(2'd3, 8'd0, 8'd4, 4'd3, 1'b0); drive(1'b1, 1'b0, 8'd0);
        exp_edge(7, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(7, 8'd3, 1'b0, 1'b0, 1'b0);
        exp_edge(7, 8'd4, 1'b0, 1'b1, 1'b1);
        exp_edge(7, 8'd4, 1'b0, 1'b1, 1'b1);
        exp_edge(7, 8'd4, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 8'd1);
        exp_edge(7, 8'd1, 1'b0, 1'b0, 1'b0);

        // lo == hi: WRAP pulses wrap, SATURATE does not
        cfg(2'd0, 8'd6, 8'd6, 4'd1, 1'b0); drive(1'b1, 1'b0, 8'd6);
        exp_edge(8, 8'd6, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(8, 8'd6, 1'b1, 1'b1, 1'b0);
        cfg(2'd1, 8'd6, 8'd6, 4'd1, 1'b0);
        exp_edge(8, 8'd6, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges, then out-of-range recovery
        cfg(2'd0, 8'd3, 8'd12, 4'd1, 1'b0); drive(1'b1, 1'b0, 8'd11);
        exp_edge(9, 8'd11, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0);
        exp_edge(9, 8'd12, 1'b0, 1'b1, 1'b0);
        exp_edge(9, 8'd3,  1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk(9, "async_rst_count", 32'(count), 32'd0);
        chk(9, "async_rst_wrap",  32'(wrap),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_edge(10, 8'd3, 1'b1, 1'b0, 1'b0);

        // lo > hi: cfg_err and count holds
        cfg(2'd0, 8'd9, 8'd3, 4'd1, 1'b0);
        #1 chk(11, "cfg_err_set", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 5; i++) exp_edge(11, 8'd3, 1'b0, 1'b1, 1'b0);
        cfg(2'd0, 8'd3, 8'd12, 4'd1, 1'b0);
        #1 chk(11, "cfg_err_clr", 32'(cfg_err), 32'd0);
        exp_edge(11, 8'd4, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        chk(12, "sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
